// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU operation at a time.
// Requests are accepted in IDLE and the opcode is translated to an ALU control
// code. Control and operands are driven to the ALU for SETTLE cycles, then the
// result and zero flag are captured and returned on the response channel.
// Illegal opcodes skip the ALU and report an error one cycle after acceptance.
module alu_op_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_taken,
    output logic       rsp_err,
    output logic [2:0] alu_ctrl_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    input  logic [7:0] alu_result_i,
    input  logic       alu_zero_i
);

    // ST_ERR is a one-cycle pass-through that gives illegal opcodes their
    // single-cycle response latency without ever touching the ALU.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_ERR   = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
    localparam logic [3:0] OP_BEQ   = 4'b0110;

    // Opcode to ALU control code; illegal opcodes map to the idle code.
    function automatic logic [2:0] decode_op(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            4'b0000: code = 3'b001;
            4'b0001: code = 3'b001;
            4'b0010: code = 3'b010;
            4'b0011: code = 3'b011;
            4'b0100: code = 3'b100;
            4'b0101: code = 3'b101;
            4'b0110: code = 3'b110;
            4'b0111: code = 3'b001;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic [7:0] res_q, res_d;
    logic       taken_q, taken_d;
    logic       err_q, err_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       req_ready_q, req_ready_d;

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        res_d       = res_q;
        taken_d     = taken_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    a_d         = req_a;
                    b_d         = req_b;
                    cnt_d       = 4'd0;
                    req_ready_d = 1'b0;
                    if (req_op[3]) begin
                        state_d = ST_ERR;
                        ctrl_d  = 3'b000;
                    end else begin
                        state_d = ST_DRIVE;
                        ctrl_d  = decode_op(req_op);
                    end
                end else begin
                    ctrl_d = 3'b000;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == LAST_CNT) begin
                    res_d       = alu_result_i;
                    taken_d     = (op_q == OP_BEQ) ? alu_zero_i : 1'b0;
                    err_d       = 1'b0;
                    ctrl_d      = 3'b000;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ERR: begin
                res_d       = 8'h00;
                taken_d     = 1'b0;
                err_d       = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 4'd0;
                ctrl_d      = 3'b000;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with immediate asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 4'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            ctrl_q      <= 3'b000;
            res_q       <= 8'h00;
            taken_q     <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            res_q       <= res_d;
            taken_q     <= taken_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_taken  = taken_q;
    assign rsp_err    = err_q;
    assign alu_ctrl_o = ctrl_q;
    assign alu_a_o    = a_q;
    assign alu_b_o    = b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer: a SETTLE=2 instance for the main
// function and a SETTLE=4 instance for reset during DRIVE.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n4 = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_valid4 = 1'b0;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       rsp_ready = 1'b0;

    logic       req_ready, rsp_valid, rsp_taken, rsp_err;
    logic [7:0] rsp_result, alu_a, alu_b, alu_res;
    logic [2:0] alu_ctrl;
    logic       alu_zero;

    logic       req_ready4, rsp_valid4, rsp_taken4, rsp_err4;
    logic [7:0] rsp_result4, alu_a4, alu_b4, alu_res4;
    logic [2:0] alu_ctrl4;
    logic       alu_zero4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference 8-bit ALU
    function automatic logic [7:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'b001:  return a + b;
            3'b010:  return ~(a & b);
            3'b011:  return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            3'b100:  return a << b[2:0];
            3'b101:  return $unsigned($signed(a) >>> b[2:0]);
            3'b110:  return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res   = alu_f(alu_ctrl, alu_a, alu_b);
    assign alu_zero  = (alu_res == 8'h00);
    assign alu_res4  = alu_f(alu_ctrl4, alu_a4, alu_b4);
    assign alu_zero4 = (alu_res4 == 8'h00);

    alu_op_sequencer #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_err(rsp_err),
        .alu_ctrl_o(alu_ctrl), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero)
    );

    alu_op_sequencer #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result4), .rsp_taken(rsp_taken4), .rsp_err(rsp_err4),
        .alu_ctrl_o(alu_ctrl4), .alu_a_o(alu_a4), .alu_b_o(alu_b4),
        .alu_result_i(alu_res4), .alu_zero_i(alu_zero4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a legal op on the SETTLE=2 instance; ends just after the capture edge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] ctrl, input logic [7:0] res, input logic taken);
        chk({tag, "_ready_idle"}, req_ready, 1'b1);
        chk({tag, "_ctrl_idle"}, alu_ctrl, 3'b000);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ctrl_drive"}, alu_ctrl, ctrl);
            chk({tag, "_ready_busy"}, req_ready, 1'b0);
            chk({tag, "_rsp_valid_early"}, rsp_valid, 1'b0);
            tick();
        end
        chk({tag, "_ctrl_after"}, alu_ctrl, 3'b000);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_taken"}, rsp_taken, taken);
        chk({tag, "_err"}, rsp_err, 1'b0);
    endtask

    // Complete the pending response with rsp_ready high for one edge.
    task automatic finish(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, rsp_valid, 1'b0);
        chk({tag, "_ready_back"}, req_ready, 1'b1);
        chk({tag, "_ctrl_back"}, alu_ctrl, 3'b000);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_result", rsp_result, 8'h00);
        chk("rst_taken", rsp_taken, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_ctrl", alu_ctrl, 3'b000);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        rst_n = 1'b1;
        tick();

        // add
        issue("add", 4'b0000, 8'h12, 8'h34, 3'b001, 8'h46, 1'b0);
        finish("add");

        // back-to-back nand
        issue("nand1", 4'b0010, 8'hF0, 8'h3C, 3'b010, 8'hCF, 1'b0);
        finish("nand1");
        issue("nand2", 4'b0010, 8'hF0, 8'h3C, 3'b010, 8'hCF, 1'b0);
        finish("nand2");

        // beq equal
        issue("beq_eq", 4'b0110, 8'h55, 8'h55, 3'b110, 8'h00, 1'b1);
        finish("beq_eq");

        // beq not equal after reset
        #2 rst_n = 1'b0;
        #1 chk("rst2_alu_a", alu_a, 8'h00);
        chk("rst2_taken", rsp_taken, 1'b0);
        rst_n = 1'b1;
        tick();
        issue("beq_ne", 4'b0110, 8'h55, 8'h54, 3'b110, 8'h01, 1'b0);
        finish("beq_ne");

        // sll producing zero: taken forced 0 for non-beq
        issue("sll_zero", 4'b0100, 8'h80, 8'h01, 3'b100, 8'h00, 1'b0);
        finish("sll_zero");
        issue("sll", 4'b0100, 8'h81, 8'h01, 3'b100, 8'h02, 1'b0);
        finish("sll");

        // illegal opcode
        req_op = 4'b1010; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ill_ctrl0", alu_ctrl, 3'b000);
        chk("ill_valid0", rsp_valid, 1'b0);
        chk("ill_ready0", req_ready, 1'b0);
        tick();
        chk("ill_ctrl1", alu_ctrl, 3'b000);
        chk("ill_valid1", rsp_valid, 1'b1);
        chk("ill_err", rsp_err, 1'b1);
        chk("ill_result", rsp_result, 8'h00);
        chk("ill_taken", rsp_taken, 1'b0);
        finish("ill");

        // slt with backpressure
        issue("slt", 4'b0011, 8'h03, 8'h07, 3'b011, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_result", rsp_result, 8'h01);
            chk("bp_ready", req_ready, 1'b0);
            chk("bp_ctrl", alu_ctrl, 3'b000);
        end
        finish("bp");

        // async reset in DRIVE on the SETTLE=4 instance
        rst_n4 = 1'b1;
        tick();
        chk("r4_ready_idle", req_ready4, 1'b1);
        req_op = 4'b0000; req_a = 8'h12; req_b = 8'h34; req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        chk("r4_ctrl_c1", alu_ctrl4, 3'b001);
        tick();
        chk("r4_ctrl_c2", alu_ctrl4, 3'b001);
        chk("r4_ready_busy", req_ready4, 1'b0);
        #2 rst_n4 = 1'b0;
        #1;
        chk("r4_ctrl_rst", alu_ctrl4, 3'b000);
        chk("r4_ready_rst", req_ready4, 1'b1);
        chk("r4_valid_rst", rsp_valid4, 1'b0);
        #1 rst_n4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("r4_no_rsp", rsp_valid4, 1'b0);
            chk("r4_ctrl_idle", alu_ctrl4, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
